// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states,
// flag bundle and the default ENC key byte.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_ENC = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ITER,
    S_DONE
  } state_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic dz;
    logic err;
  } flags_t;

  localparam logic [7:0] KEY_BYTE = 8'hAB;

  // MUL always iterates; DIV iterates only when there is a real divisor.
  function automatic logic is_iterative(logic [3:0] op, logic b_nonzero);
    return (op == OP_MUL) || ((op == OP_DIV) && b_nonzero);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between a requester and the sequential ALU.
interface seq_alu_if #(
  parameter int W = 8
);
  logic           start;
  logic [3:0]     opcode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           carry;
  logic           overflow;
  logic           zero;
  logic           dz;
  logic           err;

  modport master (
    output start, opcode, a, b,
    input  busy, done, result, carry, overflow, zero, dz, err
  );

  modport slave (
    input  start, opcode, a, b,
    output busy, done, result, carry, overflow, zero, dz, err
  );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative W-step datapath: shift-add multiply or restoring divide.
// Divide leaves {remainder, quotient}; multiply leaves the 2W-bit product.
module seq_muldiv #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic [2*W-1:0] prod_or_qr
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [W-1:0]   opnd;
  logic           div_mode;
  logic [CW-1:0]  count;
  logic [W:0]     add_sum;
  logic [W:0]     rem_shift;
  logic [W:0]     rem_diff;

  // One iteration step of whichever algorithm is loaded.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    acc_next  = acc;
    add_sum   = '0;
    rem_shift = '0;
    rem_diff  = '0;
    if (div_mode) begin
      rem_shift = acc[2*W-1:W-1];
      rem_diff  = rem_shift - {1'b0, opnd};
      if (!rem_diff[W]) acc_next = {rem_diff[W-1:0], acc[W-2:0], 1'b1};
      else              acc_next = {rem_shift[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      add_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_next = {add_sum, acc[W-1:1]};
    end
  end

  // Load operands, then run exactly W steps; busy drops after the last one.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      acc      <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
    end else if (load) begin
      acc      <= is_div ? {{W{1'b0}}, a} : {{W{1'b0}}, b};
      opnd     <= is_div ? b : a;
      div_mode <= is_div;
      count    <= CW'(W);
      busy     <= 1'b1;
    end else if (busy) begin
      acc   <= acc_next;
      count <= count - 1'b1;
      if (count == CW'(1)) busy <= 1'b0;
    end
  end

  assign prod_or_qr = acc;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: IDLE/EXEC/ITER/DONE controller with registered result
// and flags; MUL and nonzero-divisor DIV go through seq_muldiv.
module seq_alu
  import alu_pkg::*;
#(
  parameter int             W   = 8,
  parameter logic [2*W-1:0] KEY = {(2*W/8){KEY_BYTE}}
) (
  input logic       clk,
  input logic       rst,
  seq_alu_if.slave  bus
);

  state_e         state;
  logic [3:0]     op_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [2*W-1:0] result_r;
  flags_t         flags_r;
  logic           done_r;
  logic           busy_r;

  logic           md_load;
  logic           md_busy;
  logic [2*W-1:0] md_out;

  logic [2*W-1:0] exec_result;
  flags_t         exec_flags;
  flags_t         iter_flags;
  logic [W:0]     sum;
  logic [W:0]     diff;

  // The iterative unit loads on the same edge the controller accepts the request.
  assign md_load = (state == S_IDLE) && bus.start && is_iterative(bus.opcode, |bus.b);

  seq_muldiv #(.W(W)) u_muldiv (
    .clk        (clk),
    .rst        (rst),
    .load       (md_load),
    .is_div     (bus.opcode == OP_DIV),
    .a          (bus.a),
    .b          (bus.b),
    .busy       (md_busy),
    .prod_or_qr (md_out)
  );

  // Single-cycle operations computed from the captured operands.
  always_comb begin
    exec_result = '0;
    exec_flags  = '0;
    sum         = {1'b0, a_r} + {1'b0, b_r};
    diff        = {1'b0, a_r} - {1'b0, b_r};
    case (op_r)
      OP_ADD: begin
        exec_result         = {{W{1'b0}}, sum[W-1:0]};
        exec_flags.carry    = sum[W];
        exec_flags.overflow = (a_r[W-1] == b_r[W-1]) && (sum[W-1] != a_r[W-1]);
      end
      OP_SUB: begin
        exec_result         = {{W{1'b0}}, diff[W-1:0]};
        exec_flags.carry    = ~diff[W];
        exec_flags.overflow = (a_r[W-1] != b_r[W-1]) && (diff[W-1] != a_r[W-1]);
      end
      OP_MUL: exec_result = '0;  // never executed here: MUL always iterates
      OP_DIV: begin              // only reached with a zero divisor
        exec_result   = {a_r, {W{1'b1}}};
        exec_flags.dz = 1'b1;
      end
      OP_AND: exec_result = {{W{1'b0}}, a_r & b_r};
      OP_OR:  exec_result = {{W{1'b0}}, a_r | b_r};
      OP_XOR: exec_result = {{W{1'b0}}, a_r ^ b_r};
      OP_NOT: exec_result = {{W{1'b0}}, ~a_r};
      OP_ENC: exec_result = {a_r, b_r} ^ KEY;
      default: exec_flags.err = 1'b1;
    endcase
    exec_flags.zero = (exec_result == '0);
    iter_flags      = '0;
    iter_flags.zero = (md_out == '0);
  end

  // Controller: accept, execute or wait for the iterative unit, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      flags_r  <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            op_r   <= bus.opcode;
            a_r    <= bus.a;
            b_r    <= bus.b;
            busy_r <= 1'b1;
            state  <= is_iterative(bus.opcode, |bus.b) ? S_ITER : S_EXEC;
          end
        end
        S_EXEC: begin
          result_r <= exec_result;
          flags_r  <= exec_flags;
          done_r   <= 1'b1;
          state    <= S_DONE;
        end
        S_ITER: begin
          if (!md_busy) begin
            result_r <= md_out;
            flags_r  <= iter_flags;
            done_r   <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.carry    = flags_r.carry;
  assign bus.overflow = flags_r.overflow;
  assign bus.zero     = flags_r.zero;
  assign bus.dz       = flags_r.dz;
  assign bus.err      = flags_r.err;

endmodule
